// File: rtl/adaboost_pkg.sv
// adaboost_pkg: shared types, width helpers and cfg_addr offsets for the
// AdaBoost ensemble and its classifier lanes.
// Contents: FSM state enum, clog2/index/accumulator/total width functions,
//           bias/class-weight address offsets (relative to N_FEAT), prediction codes.
package adaboost_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_VOTE  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Coefficient address map: 0..N_FEAT-1 weights, then these offsets past N_FEAT.
  localparam int unsigned BIAS_OFS = 0;
  localparam int unsigned CW_OFS   = 1;

  // Two-bit signed prediction codes.
  localparam logic [1:0] PRED_POS = 2'b01;
  localparam logic [1:0] PRED_NEG = 2'b11;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Index width, never below one bit so single-entry cases still get a port.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Score accumulator: bias plus up to N_FEAT weights, all W_W signed.
  function automatic int acc_w(input int w_w, input int n_feat);
    return w_w + clog2(n_feat + 1) + 1;
  endfunction

  // Weighted-vote total: sum of N_CLF terms of magnitude up to 2^(W_W-1).
  function automatic int tot_w(input int w_w, input int n_clf);
    return w_w + clog2(n_clf) + 1;
  endfunction

endpackage

// File: rtl/adaboost_clf_lane.sv
// adaboost_clf_lane: one weak classifier -- coefficient storage, score accumulator, sign vote.
// Ports: clk/rst; wr_en_i/wr_addr_i/wr_data_i coefficient write; load_i (score <= bias),
//        acc_i/feat_bit_i/feat_idx_i (one feature per cycle); vote_o (1 = +1), cw_o class weight.
module adaboost_clf_lane
  import adaboost_pkg::*;
#(
  parameter int N_FEAT = 30,
  parameter int W_W    = 9,
  parameter int AW     = 5,
  parameter int CNT_W  = 5,
  parameter int SW     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic signed [W_W-1:0] wr_data_i,
  input  logic                  load_i,
  input  logic                  acc_i,
  input  logic                  feat_bit_i,
  input  logic [CNT_W-1:0]      feat_idx_i,
  output logic                  vote_o,
  output logic signed [W_W-1:0] cw_o
);

  logic signed [W_W-1:0] weight_q [N_FEAT];
  logic signed [W_W-1:0] bias_q;
  logic signed [W_W-1:0] cw_q;
  logic signed [W_W-1:0] w_sel;
  logic signed [SW-1:0]  score_q, score_d;
  logic                  vote_q;

  // Coefficient storage; addresses outside the map simply match nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_FEAT; k++) weight_q[k] <= '0;
      bias_q <= '0;
      cw_q   <= '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < N_FEAT; k++) begin
        if (wr_addr_i == AW'(k)) weight_q[k] <= wr_data_i;
      end
      if (wr_addr_i == AW'(N_FEAT + BIAS_OFS)) bias_q <= wr_data_i;
      if (wr_addr_i == AW'(N_FEAT + CW_OFS))   cw_q   <= wr_data_i;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (feat_idx_i == CNT_W'(k)) w_sel = weight_q[k];
    end
  end

  // Size casts of signed operands sign-extend into the wide accumulator.
  always_comb begin
    score_d = score_q;
    if (load_i) begin
      score_d = SW'(bias_q);
    end else if (acc_i && feat_bit_i) begin
      score_d = score_q + SW'(w_sel);
    end
  end

  // Vote is re-registered every cycle; the FSM samples it one cycle after the
  // final feature has been added, so it always reflects the complete score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      vote_q  <= 1'b1;
    end else begin
      score_q <= score_d;
      vote_q  <= ~score_q[SW-1];
    end
  end

  assign vote_o = vote_q;
  assign cw_o   = cw_q;

endmodule

// File: rtl/adaboost_ensemble.sv
// adaboost_ensemble: N_CLF-lane AdaBoost classifier over an N_FEAT-bit binary feature vector.
// Ports: clk, rst (async, active high); cfg_we/cfg_clf/cfg_addr/cfg_wdata/cfg_ready coefficient
//        writes; in_valid/in_ready/in_data sample; res_valid/res_ready/res_pred result.
// Optional: ADABOOST_VOTES_EN adds res_votes (per-lane vote bits, valid with res_valid).
// Timing: sample accepted on edge 0, result valid after edge N_FEAT+2, held until res_ready.
module adaboost_ensemble
  import adaboost_pkg::*;
#(
  parameter int N_CLF  = 3,
  parameter int N_FEAT = 30,
  parameter int W_W    = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [idx_w(N_CLF)-1:0]       cfg_clf,
  input  logic [idx_w(N_FEAT+2)-1:0]    cfg_addr,
  input  logic signed [W_W-1:0]         cfg_wdata,
  output logic                          cfg_ready,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_FEAT-1:0]             in_data,
  output logic                          res_valid,
  input  logic                          res_ready,
`ifdef ADABOOST_VOTES_EN
  output logic [N_CLF-1:0]              res_votes,
`endif
  output logic [1:0]                    res_pred
);

  localparam int CLF_W = idx_w(N_CLF);
  localparam int AW    = idx_w(N_FEAT + 2);
  localparam int CNT_W = idx_w(N_FEAT);
  localparam int SW    = acc_w(W_W, N_FEAT);
  localparam int TW    = tot_w(W_W, N_CLF);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [N_FEAT-1:0]   data_q, data_d;
  logic [1:0]          pred_q, pred_d;
  logic                load;
  logic                acc;
  logic                cfg_wr;

  logic [N_CLF-1:0]      lane_vote;
  logic signed [W_W-1:0] lane_cw [N_CLF];
  logic signed [TW-1:0]  total;

  assign cfg_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_pred  = pred_q;
  assign cfg_wr    = cfg_we && cfg_ready;

  for (genvar c = 0; c < N_CLF; c++) begin : g_lane
    adaboost_clf_lane #(
      .N_FEAT (N_FEAT),
      .W_W    (W_W),
      .AW     (AW),
      .CNT_W  (CNT_W),
      .SW     (SW)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (cfg_wr && (cfg_clf == CLF_W'(c))),
      .wr_addr_i  (cfg_addr),
      .wr_data_i  (cfg_wdata),
      .load_i     (load),
      .acc_i      (acc),
      .feat_bit_i (data_q[cnt_q]),
      .feat_idx_i (cnt_q),
      .vote_o     (lane_vote[c]),
      .cw_o       (lane_cw[c])
    );
  end

  // Weighted vote: +cw for a positive lane, -cw for a negative one.
  always_comb begin
    total = '0;
    for (int c = 0; c < N_CLF; c++) begin
      if (lane_vote[c]) total = total + TW'(lane_cw[c]);
      else              total = total - TW'(lane_cw[c]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    data_d  = data_q;
    pred_d  = pred_q;
    load    = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc   = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_FEAT - 1)) begin
          phase_d = 1'b0;
          state_d = ST_VOTE;
        end
      end
      ST_VOTE: begin
        // Phase 0 lets the lanes register their final sign; phase 1 resolves the total.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          pred_d  = (total >= 0) ? PRED_POS : PRED_NEG;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      data_q  <= '0;
      pred_q  <= PRED_POS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      pred_q  <= pred_d;
    end
  end

`ifdef ADABOOST_VOTES_EN
  logic [N_CLF-1:0] votes_q;

  // Captured on the same edge as the prediction so both stay stable through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      votes_q <= '0;
    end else if (state_q == ST_VOTE && phase_q) begin
      votes_q <= lane_vote;
    end
  end

  assign res_votes = votes_q;
`endif

endmodule

// File: tb/tb_adaboost_ensemble.sv
module tb_adaboost_ensemble;

  localparam int N_CLF  = 3;
  localparam int N_FEAT = 30;
  localparam int W_W    = 9;
  localparam logic [1:0] POS = 2'b01;
  localparam logic [1:0] NEG = 2'b11;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [1:0]        cfg_clf;
  logic [4:0]        cfg_addr;
  logic signed [8:0] cfg_wdata;
  logic              cfg_ready;
  logic              in_valid;
  logic              in_ready;
  logic [29:0]       in_data;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_pred;
`ifdef ADABOOST_VOTES_EN
  logic [2:0]        res_votes;
`endif

  int n_checks;
  int n_fail;

  adaboost_ensemble #(.N_CLF(N_CLF), .N_FEAT(N_FEAT), .W_W(W_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_clf   (cfg_clf),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
`ifdef ADABOOST_VOTES_EN
    .res_votes (res_votes),
`endif
    .res_pred  (res_pred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All driving and sampling happens on the falling edge.
  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int clf, input int addr, input int val);
    cfg_we    = 1'b1;
    cfg_clf   = 2'(clf);
    cfg_addr  = 5'(addr);
    cfg_wdata = 9'(val);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Drives one sample from IDLE and reports res_valid after edge 31 and edge 32.
  task automatic run_sample(input logic [29:0] d, output logic v31, output logic v32,
                            output logic [1:0] pred);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    for (int e = 1; e <= 31; e++) @(negedge clk);
    v31 = res_valid;
    @(negedge clk);
    v32  = res_valid;
    pred = res_pred;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // clf0: weight[0]=100, bias=b0; clf1/clf2 bias -1; class weights as given.
  task automatic setup_feat0(input int b0, input int cw0, input int cw1, input int cw2);
    cfg_write(0, 0, 100);
    cfg_write(0, 30, b0);
    cfg_write(1, 30, -1);
    cfg_write(2, 30, -1);
    cfg_write(0, 31, cw0);
    cfg_write(1, 31, cw1);
    cfg_write(2, 31, cw2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_res_valid: got %b expected 0", res_valid);
    end
    n_checks++;
    if (res_pred !== POS) begin
      n_fail++;
      $display("FAIL reset_res_pred: got %b expected %b", res_pred, POS);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready=%b cfg_ready=%b expected 1/1", in_ready, cfg_ready);
    end
  endtask

  task automatic test_all_negative();
    logic v31, v32;
    logic [1:0] p;
    apply_reset();
    for (int c = 0; c < 3; c++) cfg_write(c, 30, -1);
    cfg_write(0, 31, 255);
    cfg_write(1, 31, 238);
    cfg_write(2, 31, 210);
    run_sample(30'h0, v31, v32, p);
    n_checks++;
    if (v31 !== 1'b0 || v32 !== 1'b1) begin
      n_fail++;
      $display("FAIL allneg_latency: got v31=%b v32=%b expected 0/1", v31, v32);
    end
    n_checks++;
    if (p !== NEG) begin
      n_fail++;
      $display("FAIL allneg_zeros_pred: got %b expected %b", p, NEG);
    end
    run_sample(30'h3FFF_FFFF, v31, v32, p);
    n_checks++;
    if (v32 !== 1'b1 || p !== NEG) begin
      n_fail++;
      $display("FAIL allneg_ones_pred: got valid=%b pred=%b expected 1/%b", v32, p, NEG);
    end
  endtask

  task automatic test_single_feature();
    logic v31, v32;
    logic [1:0] p;
    apply_reset();
    setup_feat0(-50, 255, 100, 100);
    // score0 = 50 -> +1; total = 255 - 100 - 100 = 55
    run_sample(30'h1, v31, v32, p);
    n_checks++;
    if (v32 !== 1'b1 || p !== POS) begin
      n_fail++;
      $display("FAIL feat0_total55: got valid=%b pred=%b expected 1/%b", v32, p, POS);
    end
    // feature 0 clear -> score0 = -50 -> all votes -1
    run_sample(30'h2, v31, v32, p);
    n_checks++;
    if (p !== NEG) begin
      n_fail++;
      $display("FAIL feat0_clear: got %b expected %b", p, NEG);
    end
    // total = 255 - 238 - 210 = -193
    cfg_write(1, 31, 238);
    cfg_write(2, 31, 210);
    run_sample(30'h1, v31, v32, p);
    n_checks++;
    if (p !== NEG) begin
      n_fail++;
      $display("FAIL feat0_total_m193: got %b expected %b", p, NEG);
    end
  endtask

  task automatic test_tie_and_zero_score();
    logic v31, v32;
    logic [1:0] p;
    apply_reset();
    setup_feat0(-50, 100, 50, 50);
    // total = 100 - 50 - 50 = 0 -> tie resolves to +1
    run_sample(30'h1, v31, v32, p);
    n_checks++;
    if (p !== POS) begin
      n_fail++;
      $display("FAIL tie_total0: got %b expected %b", p, POS);
    end
    // score0 exactly 0 counts as a +1 vote: total = 55
    cfg_write(0, 30, -100);
    cfg_write(0, 31, 255);
    cfg_write(1, 31, 100);
    cfg_write(2, 31, 100);
    run_sample(30'h1, v31, v32, p);
    n_checks++;
    if (p !== POS) begin
      n_fail++;
      $display("FAIL score_zero_pos: got %b expected %b", p, POS);
    end
    // score0 = -1 -> all -1
    cfg_write(0, 30, -101);
    run_sample(30'h1, v31, v32, p);
    n_checks++;
    if (p !== NEG) begin
      n_fail++;
      $display("FAIL score_m1_neg: got %b expected %b", p, NEG);
    end
  endtask

  task automatic test_backpressure();
    logic v31, v32;
    logic [1:0] p;
    int bad;
    apply_reset();
    setup_feat0(-50, 255, 100, 100);
    in_valid = 1'b1;
    in_data  = 30'h1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 1; e <= 32; e++) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_pred !== POS) begin
      n_fail++;
      $display("FAIL bp_first_result: got valid=%b pred=%b expected 1/%b", res_valid, res_pred, POS);
    end
    // Stall with a competing sample offered; it must not be taken.
    in_valid = 1'b1;
    in_data  = 30'h0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_pred !== POS || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d bad stall cycles expected 0", bad);
    end
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done_in_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_back_idle: got valid=%b in_ready=%b expected 0/1", res_valid, in_ready);
    end
    // Second sample (feature 0 clear) only now accepted: -1 at edge 32.
    run_sample(30'h0, v31, v32, p);
    n_checks++;
    if (v31 !== 1'b0 || v32 !== 1'b1 || p !== NEG) begin
      n_fail++;
      $display("FAIL bp_second: got v31=%b v32=%b pred=%b expected 0/1/%b", v31, v32, p, NEG);
    end
  endtask

  task automatic test_reset_mid_accum();
    logic v31, v32;
    logic [1:0] p;
    apply_reset();
    for (int c = 0; c < 3; c++) cfg_write(c, 30, -1);
    cfg_write(0, 31, 255);
    cfg_write(1, 31, 238);
    cfg_write(2, 31, 210);
    in_valid = 1'b1;
    in_data  = 30'h3FF;
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 1; e <= 10; e++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || res_pred !== POS) begin
      n_fail++;
      $display("FAIL midrst_outputs: got valid=%b pred=%b expected 0/%b", res_valid, res_pred, POS);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || cfg_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got in_ready=%b cfg_ready=%b valid=%b expected 1/1/0",
               in_ready, cfg_ready, res_valid);
    end
    // Coefficients cleared: every score 0 -> +1 votes, total 0 -> +1.
    run_sample(30'h3FFF_FFFF, v31, v32, p);
    n_checks++;
    if (v32 !== 1'b1 || p !== POS) begin
      n_fail++;
      $display("FAIL midrst_cleared: got valid=%b pred=%b expected 1/%b", v32, p, POS);
    end
  endtask

  task automatic test_cfg_drop();
    logic v31, v32;
    logic [1:0] p;
    apply_reset();
    setup_feat0(-50, 255, 100, 100);
    in_valid = 1'b1;
    in_data  = 30'h1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int e = 1; e <= 10; e++) @(negedge clk);
    cfg_we    = 1'b1;
    cfg_clf   = 2'd0;
    cfg_addr  = 5'd30;
    cfg_wdata = -9'sd200;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_cfg_ready: got %b expected 0", cfg_ready);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    for (int e = 12; e <= 32; e++) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_pred !== POS) begin
      n_fail++;
      $display("FAIL drop_current: got valid=%b pred=%b expected 1/%b", res_valid, res_pred, POS);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    run_sample(30'h1, v31, v32, p);
    n_checks++;
    if (p !== POS) begin
      n_fail++;
      $display("FAIL drop_next: got %b expected %b", p, POS);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_clf   = '0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;
    test_reset();
    test_all_negative();
    test_single_feature();
    test_tie_and_zero_score();
    test_backpressure();
    test_reset_mid_accum();
    test_cfg_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adaboost_ensemble.md
ADABOOST_ENSEMBLE -- requirements
Module: adaboost_ensemble

Interface
REQ-001 SHALL have parameter N_CLF, default 3, number of weak classifiers.
REQ-002 SHALL have parameter N_FEAT, default 30, number of binary features per sample.
REQ-003 SHALL have parameter W_W, default 9, signed coefficient width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_we  in  1  coefficient write strobe.
REQ-007 SHALL have port cfg_clf  in  clog2(N_CLF)  target classifier.
REQ-008 SHALL have port cfg_addr  in  clog2(N_FEAT+2)  0..N_FEAT-1 weight, N_FEAT bias, N_FEAT+1 class weight.
REQ-009 SHALL have port cfg_wdata  in  W_W signed  coefficient value.
REQ-010 SHALL have port cfg_ready  out  1  write accepted this cycle when high.
REQ-011 SHALL have port in_valid / in_ready  in / out  1  sample handshake.
REQ-012 SHALL have port in_data  in  N_FEAT  feature vector, bit k = feature k.
REQ-013 SHALL have port res_valid / res_ready  out / in  1  result handshake.
REQ-014 SHALL have port res_pred  out  2 signed  +1 (2'b01) or -1 (2'b11).

Function
REQ-015 SHALL implement FSM IDLE -> ACCUM -> VOTE -> DONE -> IDLE.
REQ-016 SHALL assert in_ready and cfg_ready only in IDLE; writes with cfg_ready low SHALL be dropped; cfg_addr > N_FEAT+1 or cfg_clf >= N_CLF SHALL be ignored.
REQ-017 SHALL capture in_data on in_valid&&in_ready and enter ACCUM.
REQ-018 SHALL in ACCUM process one feature per cycle, k = 0..N_FEAT-1, all classifiers in parallel: score_c += weight[c][k] if bit k = 1, else +0; score_c initialised to bias[c].
REQ-019 SHALL size score accumulators W_W+clog2(N_FEAT+1)+1 bits, signed, never overflowing.
REQ-020 SHALL in VOTE form vote_c = +1 if score_c >= 0 else -1, and total = sum of vote_c*class_weight[c] in W_W+clog2(N_CLF)+1 bits.
REQ-021 SHALL set res_pred = +1 if total >= 0 (tie -> +1), else -1; res_valid SHALL rise on the (N_FEAT+2)th edge after acceptance.
REQ-022 SHALL hold res_valid and res_pred stable in DONE until res_ready high; IDLE next cycle; in_ready low during DONE even if res_ready high.
REQ-023 SHALL ignore in_valid outside IDLE without corrupting the active sample.

Reset
REQ-024 SHALL on rst (any state, any time) force IDLE, res_valid=0, res_pred=2'b01, all scores and coefficients 0; in_ready/cfg_ready high from the first edge after release.

Configuration
REQ-025 SHALL with ADABOOST_VOTES_EN defined add output res_votes (N_CLF bits, bit c = 1 when vote_c = +1), valid with res_valid; without it the port and its registers SHALL be absent.

Structure
REQ-026 SHALL place FSM state enum, width functions (clog2, accumulator widths) and cfg_addr offset constants (bias, class weight) in package adaboost_pkg.
REQ-027 SHALL instantiate N_CLF copies of sub-module adaboost_clf_lane (coefficient storage, accumulator, sign vote).

Verification (N_CLF=3, N_FEAT=30, W_W=9)
REQ-028 SHALL check: all weights 0, biases -1, class weights 255/238/210, any sample -> res_pred -1 at edge 32.
REQ-029 SHALL check: clf0 weight[0]=100, bias0=-50, in_data bit0=1, others bias -1, class weights 255/100/100 -> total 55, res_pred +1; class weights 255/238/210 -> res_pred -1.
REQ-030 SHALL check: class weights 100/50/50, votes +1/-1/-1 -> total 0 -> res_pred +1.
REQ-031 SHALL check: res_ready low 5 cycles after res_valid -> res_pred held, in_ready low, second in_valid accepted only after IDLE.
REQ-032 SHALL check: rst pulse at ACCUM feature 10 -> IDLE, res_valid 0, coefficients read back as zero effect (next sample -> +1 with biases 0).
REQ-033 SHALL check: cfg_we in ACCUM with bias0=-200 -> dropped, current and next results unchanged.
